// File: rtl/fc_mac_seq.sv
// fc_mac_seq: one fully-connected neuron computed as a sequential multiply-accumulate.
//
// A start pulse in IDLE clears the accumulator and beat counter and captures the bias.
// ACCUM then accepts N_IN activation/weight beats over a valid/ready handshake and adds
// each full-precision signed product into a wide accumulator. BIAS adds the bias,
// saturates the sum to OUT_W bits (optionally applying ReLU) and registers the result.
// OUT holds the result until the consumer takes it, then the block returns to IDLE.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a neuron (sampled only in IDLE)
//   bias       signed bias, captured with an accepted start
//   in_valid   activation/weight beat valid
//   in_ready   beat accepted when in_valid && in_ready (high only in ACCUM)
//   in_data    signed activation
//   in_wgt     signed weight
//   out_valid  result valid, held until taken
//   out_ready  result taken when out_valid && out_ready
//   out_data   signed (saturated, optionally rectified) result
//   out_sat    result was clipped by saturation
//   busy       high whenever the block is not in IDLE
module fc_mac_seq #(
    parameter int DATA_W = 30,
    parameter int WGT_W  = 9,
    parameter int N_IN   = 3136,
    parameter int ACC_W  = 56,
    parameter int OUT_W  = 38,
    parameter int RELU   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [WGT_W-1:0]  bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [WGT_W-1:0]  in_wgt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     busy
);

    localparam int PROD_W = DATA_W + WGT_W;
    // N_IN is at most 65535, so 16 bits hold every counter value.
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_IN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_BIAS  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // Largest / smallest values representable in OUT_W bits, expressed at ACC_W.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [OUT_W-1:0] RES_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] RES_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [1:0]               state_reg, state_next;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic signed [WGT_W-1:0]  bias_reg;
    logic signed [OUT_W-1:0]  out_data_reg;
    logic                     out_sat_reg;

    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] wgt_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  sum;
    logic [OUT_W-1:0]         res_next;
    logic                     sat_next;

    logic beat_fire;
    logic last_beat;
    logic out_fire;

    assign beat_fire = (state_reg == ST_ACCUM) && in_valid;
    assign last_beat = beat_fire && (cnt_reg == LAST_BEAT);
    assign out_fire  = (state_reg == ST_OUT) && out_ready;

    // Both operands widened to the product width first, so the multiply is exact.
    assign data_ext = {{WGT_W{in_data[DATA_W-1]}}, in_data};
    assign wgt_ext  = {{DATA_W{in_wgt[WGT_W-1]}}, in_wgt};
    assign prod     = data_ext * wgt_ext;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-WGT_W){bias_reg[WGT_W-1]}}, bias_reg};
    assign sum      = acc_reg + bias_ext;

    // Saturate first; ReLU afterwards so out_sat reports clipping of the raw sum.
    always_comb begin
        res_next = sum[OUT_W-1:0];
        sat_next = 1'b0;
        if (sum > SAT_MAX) begin
            res_next = RES_MAX;
            sat_next = 1'b1;
        end else if (sum < SAT_MIN) begin
            res_next = RES_MIN;
            sat_next = 1'b1;
        end
        if ((RELU != 0) && res_next[OUT_W-1]) begin
            res_next = '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start)     state_next = ST_ACCUM;
            ST_ACCUM: if (last_beat) state_next = ST_BIAS;
            ST_BIAS:                 state_next = ST_OUT;
            ST_OUT:   if (out_ready) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            bias_reg     <= '0;
            out_data_reg <= '0;
            out_sat_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && start) begin
                acc_reg  <= '0;
                cnt_reg  <= '0;
                bias_reg <= bias;
            end
            if (beat_fire) begin
                acc_reg <= acc_reg + prod_ext;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (state_reg == ST_BIAS) begin
                out_data_reg <= res_next;
                out_sat_reg  <= sat_next;
            end
            if (out_fire) begin
                out_data_reg <= '0;
                out_sat_reg  <= 1'b0;
            end
        end
    end

    assign in_ready  = (state_reg == ST_ACCUM);
    assign out_valid = (state_reg == ST_OUT);
    assign busy      = (state_reg != ST_IDLE);
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_fc_mac_seq.sv
// Testbench for fc_mac_seq: four instances cover the default widths with N_IN=4,
// a narrow 8-bit output (plain and ReLU), and the full default configuration.
// Expected results come from a behavioural model and go through a scoreboard queue.
module tb_fc_mac_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [8:0]  bias = '0;
    logic               in_valid = 1'b0;
    logic signed [29:0] in_data = '0;
    logic signed [8:0]  in_wgt = '0;
    logic               out_ready = 1'b0;
    int                 sel = 0;

    logic start_a, start_b, start_c, start_d;
    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);
    assign start_d = start && (sel == 3);

    logic in_ready_a, out_valid_a, out_sat_a, busy_a;
    logic in_ready_b, out_valid_b, out_sat_b, busy_b;
    logic in_ready_c, out_valid_c, out_sat_c, busy_c;
    logic in_ready_d, out_valid_d, out_sat_d, busy_d;
    logic signed [37:0] out_data_a, out_data_d;
    logic signed [7:0]  out_data_b, out_data_c;

    fc_mac_seq #(.N_IN(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_wgt(in_wgt),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_sat(out_sat_a), .busy(busy_a));

    fc_mac_seq #(.DATA_W(16), .N_IN(2), .ACC_W(32), .OUT_W(8), .RELU(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data[15:0]), .in_wgt(in_wgt),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_sat(out_sat_b), .busy(busy_b));

    fc_mac_seq #(.DATA_W(16), .N_IN(2), .ACC_W(32), .OUT_W(8), .RELU(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data[15:0]), .in_wgt(in_wgt),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .out_sat(out_sat_c), .busy(busy_c));

    fc_mac_seq dut_d (
        .clk(clk), .rst(rst), .start(start_d), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_d), .in_data(in_data), .in_wgt(in_wgt),
        .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d),
        .out_sat(out_sat_d), .busy(busy_d));

    // Outputs of the instance currently under test.
    logic   cur_in_ready, cur_out_valid, cur_out_sat, cur_busy;
    longint cur_out_data;
    always_comb begin
        cur_in_ready  = in_ready_a;
        cur_out_valid = out_valid_a;
        cur_out_sat   = out_sat_a;
        cur_busy      = busy_a;
        cur_out_data  = longint'(out_data_a);
        case (sel)
            1: begin cur_in_ready = in_ready_b; cur_out_valid = out_valid_b; cur_out_sat = out_sat_b;
                     cur_busy = busy_b; cur_out_data = longint'(out_data_b); end
            2: begin cur_in_ready = in_ready_c; cur_out_valid = out_valid_c; cur_out_sat = out_sat_c;
                     cur_busy = busy_c; cur_out_data = longint'(out_data_c); end
            3: begin cur_in_ready = in_ready_d; cur_out_valid = out_valid_d; cur_out_sat = out_sat_d;
                     cur_busy = busy_d; cur_out_data = longint'(out_data_d); end
            default: ;
        endcase
    end

    int total = 0;
    int bad   = 0;

    int     d_q[$];
    int     w_q[$];
    int     g_q[$];
    longint exp_d_q[$];
    bit     exp_s_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint model(input longint s, input int ow, input bit relu, output bit sat);
        longint mx, mn, r;
        mx  = (longint'(1) <<< (ow - 1)) - 1;
        mn  = -mx - 1;
        r   = s;
        sat = 1'b0;
        if (s > mx) begin r = mx; sat = 1'b1; end
        else if (s < mn) begin r = mn; sat = 1'b1; end
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    task automatic add_beats(input int n, input int d, input int w, input int gap);
        for (int i = 0; i < n; i++) begin
            d_q.push_back(d); w_q.push_back(w); g_q.push_back(gap);
        end
    endtask

    // Starts a neuron on the selected instance and plays the queued beats. Returns
    // right after the edge that accepts the last beat (the instance is then in BIAS).
    task automatic feed(input int s, input int b, input int ow, input bit relu);
        longint acc;
        longint r;
        bit     sat;
        sel   = s;
        acc   = longint'(b);
        bias  = 9'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        bias  = '0;
        while (d_q.size() > 0) begin
            int g, d, w;
            g = g_q.pop_front();
            d = d_q.pop_front();
            w = w_q.pop_front();
            in_valid = 1'b0;
            repeat (g) tick();
            in_valid = 1'b1;
            in_data  = 30'(d);
            in_wgt   = 9'(w);
            acc += longint'(d) * longint'(w);
            tick();
        end
        in_valid = 1'b0;
        r = model(acc, ow, relu, sat);
        exp_d_q.push_back(r);
        exp_s_q.push_back(sat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #0;
            total++;
            if ({cur_busy, cur_in_ready, cur_out_valid, cur_out_sat} !== 4'b0000 || cur_out_data !== 0) begin
                bad++;
                $display("FAIL reset_state sel=%0d busy=%0b in_ready=%0b out_valid=%0b sat=%0b data=%0d required all 0",
                         s, cur_busy, cur_in_ready, cur_out_valid, cur_out_sat, cur_out_data);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        longint ed;
        bit     es;
        for (int i = 1; i <= 4; i++) add_beats(1, i, 1, 0);
        feed(0, 3, 38, 1'b0);
        total++;
        if (cur_out_valid !== 1'b0 || cur_busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_bias_cycle out_valid=%0b busy=%0b required 0/1", cur_out_valid, cur_busy);
        end
        tick();
        total++;
        if (cur_out_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_latency out_valid=%0b required 1 at T+2", cur_out_valid);
        end
        ed = exp_d_q.pop_front();
        es = exp_s_q.pop_front();
        $display("basic: data=%0d sat=%0b exp=%0d/%0b", cur_out_data, cur_out_sat, ed, es);
        total++;
        if (cur_out_data !== ed || cur_out_sat !== es) begin
            bad++;
            $display("FAIL basic_result got=%0d/%0b required=%0d/%0b", cur_out_data, cur_out_sat, ed, es);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (cur_out_valid !== 1'b0 || cur_busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_return_idle out_valid=%0b busy=%0b required 0/0", cur_out_valid, cur_busy);
        end
    endtask

    // Waits (bounded) for a result on the selected instance, compares it and takes it.
    task automatic test_collect(input string name);
        longint ed;
        bit     es;
        int     n;
        n = 0;
        while (cur_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        ed = exp_d_q.pop_front();
        es = exp_s_q.pop_front();
        total++;
        if (cur_out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout out_valid=%0b required 1 within 20 cycles", name, cur_out_valid);
        end else begin
            $display("%s: data=%0d sat=%0b exp=%0d/%0b", name, cur_out_data, cur_out_sat, ed, es);
            if (cur_out_data !== ed || cur_out_sat !== es) begin
                bad++;
                $display("FAIL %s_result got=%0d/%0b required=%0d/%0b", name, cur_out_data, cur_out_sat, ed, es);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_gaps();
        // in_valid pattern 1,0,0,1,1,0,1 -> idle cycles before each beat: 0,2,0,1
        add_beats(1, -5, 7, 0);
        add_beats(1, -5, 7, 2);
        add_beats(1, -5, 7, 0);
        add_beats(1, -5, 7, 1);
        feed(0, -2, 38, 1'b0);
        test_collect("gaps");
    endtask

    task automatic test_saturation();
        add_beats(2, 100, 100, 0);
        feed(1, 0, 8, 1'b0);
        test_collect("sat_pos");
        add_beats(2, 100, -100, 0);
        feed(1, 0, 8, 1'b0);
        test_collect("sat_neg");
        add_beats(2, 100, -100, 0);
        feed(2, 0, 8, 1'b1);
        test_collect("sat_relu_neg");
        add_beats(2, 3, -4, 1);
        feed(2, 5, 8, 1'b1);
        test_collect("relu_small");
    endtask

    task automatic test_hold();
        longint ed;
        bit     es;
        add_beats(4, 6, -3, 0);
        feed(0, 1, 38, 1'b0);
        tick();
        ed = exp_d_q.pop_front();
        es = exp_s_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            total++;
            if (cur_out_valid !== 1'b1 || cur_out_data !== ed || cur_out_sat !== es) begin
                bad++;
                $display("FAIL hold_stable cycle=%0d valid=%0b data=%0d sat=%0b required 1/%0d/%0b",
                         i, cur_out_valid, cur_out_data, cur_out_sat, ed, es);
            end
            tick();
        end
        // Start coinciding with the taking handshake must be ignored.
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        $display("hold: taken data=%0d", ed);
        total++;
        if (cur_busy !== 1'b0 || cur_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_handshake busy=%0b out_valid=%0b required 0/0", cur_busy, cur_out_valid);
        end
        tick();
        total++;
        if (cur_busy !== 1'b0 || cur_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_start_ignored busy=%0b in_ready=%0b required 0/0", cur_busy, cur_in_ready);
        end
    endtask

    task automatic test_reset_mid();
        sel   = 0;
        bias  = 9'sd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = 30'sd1000;
        in_wgt   = 9'sd100;
        repeat (2) tick();
        in_valid = 1'b0;
        total++;
        if (cur_in_ready !== 1'b1 || cur_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_accum in_ready=%0b busy=%0b required 1/1", cur_in_ready, cur_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (cur_busy !== 1'b0 || cur_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset busy=%0b in_ready=%0b required 0/0", cur_busy, cur_in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            tick();
            total++;
            if (cur_out_valid !== 1'b0 || cur_busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_no_output cycle=%0d out_valid=%0b busy=%0b required 0/0",
                         i, cur_out_valid, cur_busy);
            end
        end
        in_valid = 1'b0;
        add_beats(4, 1, 2, 0);
        feed(0, 0, 38, 1'b0);
        test_collect("after_reset");
    endtask

    task automatic test_back_to_back();
        add_beats(4, -536870912, -256, 0);
        feed(0, 255, 38, 1'b0);
        test_collect("b2b_first");
        add_beats(4, 123456, 77, 0);
        feed(0, -256, 38, 1'b0);
        test_collect("b2b_second");
    endtask

    task automatic test_full();
        add_beats(3136, 536870911, -256, 0);
        feed(3, 0, 38, 1'b0);
        test_collect("full_length");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_saturation();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
